// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned word commit.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIG = 4,
    parameter int PERIOD  = 50000,
    parameter int GUARD   = 500
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iLOAD,
    input  logic [4*NUM_DIG-1:0]   iDATA,
    output logic                   oACK,
    output logic                   oPEND,
    output logic [NUM_DIG-1:0]     oAN,
    output logic [6:0]             oSEG
);

    localparam int CW = $clog2(PERIOD);
    localparam int DW = $clog2(NUM_DIG);
    localparam int WW = 4 * NUM_DIG;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIG - 1);

    logic [CW-1:0]      cnt;
    logic [DW-1:0]      dig;
    logic [WW-1:0]      shadowWord;
    logic [WW-1:0]      activeWord;
    logic               pending;

    logic               dwellEnd;
    logic               frameEnd;
    logic               commit;
    logic [3:0]         nibble;
    logic               blankDigit;
    logic [NUM_DIG-1:0] anNext;
    logic [6:0]         segNext;

    function automatic logic [6:0] hexToSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        dwellEnd   = (cnt == CNT_LAST);
        frameEnd   = dwellEnd && (dig == DIG_LAST);
        commit     = frameEnd && pending;
        nibble     = '0;
        blankDigit = 1'b0;
        anNext     = '1;
        segNext    = 7'h7F;

        for (int i = 0; i < NUM_DIG; i++) begin
            if (DW'(i) == dig) nibble = activeWord[4*i +: 4];
        end

`ifdef SEG7_LZB_EN
        // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
        for (int i = 1; i < NUM_DIG; i++) begin
            if (DW'(i) == dig) blankDigit = ((activeWord >> (4*i)) == '0);
        end
`endif

        if (cnt >= GUARD_C) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                anNext[i] = (DW'(i) != dig);
            end
            segNext = blankDigit ? 7'h7F : hexToSeg(nibble);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt        <= '0;
            dig        <= '0;
            shadowWord <= '0;
            activeWord <= '0;
            pending    <= 1'b0;
            oACK       <= 1'b0;
            oAN        <= '1;
            oSEG       <= 7'h7F;
        end else begin
            cnt <= dwellEnd ? '0 : cnt + 1'b1;
            if (dwellEnd) dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;

            // Commit takes the pre-load shadow; a coincident load re-arms pending for the next frame.
            if (commit) activeWord <= shadowWord;
            if (iLOAD)  shadowWord <= iDATA;
            pending <= iLOAD | (pending & ~commit);

            oACK <= commit;
            oAN  <= anNext;
            oSEG <= segNext;
        end
    end

    assign oPEND = pending;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It shares one hex-to-segment decode path among NUM_DIG digits, rotating the active digit at a programmable dwell rate with a guard (ghost-suppression) interval at each switch. New display words arrive through a load/acknowledge handshake and are committed only at frame boundaries, so the display never shows a partially updated word. It sits between any status or debug source and the board's digit/segment pins.

## Interface
- NUM_DIG, 4, number of digits scanned; legal 2..8
- PERIOD, 50000, dwell per digit in iCLK cycles; legal 4..2^20
- GUARD, 500, blanked cycles at the start of each dwell; legal 1..PERIOD-2
- iCLK  in  1  system clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iLOAD  in  1  one-cycle strobe: capture iDATA into the shadow register
- iDATA  in  4*NUM_DIG  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant
- oACK  out  1  one-cycle pulse: shadow word committed to display
- oPEND  out  1  shadow holds an uncommitted word
- oAN  out  NUM_DIG  digit enables, active-low
- oSEG  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Internal state: tick counter cnt (0..PERIOD-1), digit index dig (0..NUM_DIG-1), shadow word, active word, pending flag.
- cnt increments every cycle; at cnt==PERIOD-1 it returns to 0 and dig advances, wrapping from NUM_DIG-1 to 0.
- Phases within a dwell: BLANK while cnt<GUARD, DRIVE otherwise.
- BLANK: oAN all ones, oSEG=7'h7F.
- DRIVE: oAN has only bit dig low; oSEG is the active-low hex decode of active nibble dig: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- iLOAD=1: shadow<=iDATA, pending<=1. Repeated loads while pending overwrite the shadow; last write wins; exactly one oACK follows.
- Frame end is cnt==PERIOD-1 with dig==NUM_DIG-1. At frame end, if pending was set before this cycle: active<=shadow, pending<=0, oACK=1 next cycle.
- iLOAD coincident with a committing frame end: the commit uses the pre-load shadow, then the new iDATA is captured and pending stays 1, committing at the next frame end.
- iLOAD coincident with a frame end and no prior pending: captured and pending; commits at the next frame end.

## Timing
- All outputs registered; oAN/oSEG reflect the cnt/dig/active state of the previous cycle.
- Reset values: cnt=0, dig=0, shadow=0, active=0, pending=0, oACK=0, oPEND=0, oAN=all ones, oSEG=7'h7F.
- First DRIVE of digit 0 appears on the outputs at cycle GUARD+1 after reset release.
- Load-to-display latency: iLOAD to oACK ranges from 2 cycles to NUM_DIG*PERIOD+1 cycles; the new word shows on the first DRIVE after the commit.
- oPEND rises the cycle after iLOAD and falls in the same cycle oACK rises.
- Reset mid-frame or with a pending word clears everything immediately. The pending word is discarded and no oACK is issued.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking is active. Starting from digit NUM_DIG-1 downward, each digit whose active nibble is 0 and lies above the highest nonzero nibble shows oSEG=7'h7F during DRIVE; its oAN bit is still asserted. Digit 0 is never blanked.
- Not defined: every digit is decoded normally, including leading zeros.

## Test plan
- Reset, then run with NUM_DIG=4, PERIOD=8, GUARD=2 -> oAN=F, oSEG=7F through cycle 2. oAN=E and oSEG=40 from cycle 3 to 8. oAN=D from cycle 11.
- iLOAD with iDATA=16'h1A2F mid-frame -> oPEND=1 and oACK=0 until the frame end. Then one oACK pulse, and the next frame shows 0E, 24, 08, 79 on digits 0..3.
- Two iLOADs (16'h1111, then 16'h2222) in the same frame -> single oACK; the display shows 24 on all digits and never shows 79.
- iLOAD at the committing frame-end cycle -> the old shadow is committed with oACK. oPEND stays 1 and the new word commits one frame later.
- Assert iRST with a pending word during DRIVE -> outputs go to F/7F asynchronously, oPEND=0, and no oACK is issued after release.
- With SEG7_LZB_EN and iDATA=16'h0050 -> digits 3 and 2 show 7F, digit 1 shows 12, and digit 0 shows 40. iDATA=0 shows 40 on digit 0 only.
